// File: rtl/mux_sched_pkg.sv
// Shared constants, state encoding and helpers for the round-robin mux scheduler.
package mux_sched_pkg;

    localparam int NUM_REQ  = 4;
    localparam int SEL_W    = 2;
    localparam int SETTLE_W = 4;   // holds SETTLE_CYC up to 15
    localparam int HOLD_W   = 8;   // holds HOLD_MAX up to 255

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GRANT  = 2'd2
    } state_e;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request after 'last', wrapping modulo 4.
module rr_pick
    import mux_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic [SEL_W-1:0]   winner,
    output logic               any
);

    logic [SEL_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;

    // Position gi in the scan order is index last+1+gi; the index wraps through the select width.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        assign cand_idx[gi] = last + SEL_W'(gi + 1);
        assign cand_hit[gi] = req[cand_idx[gi]];
    end

    always_comb begin
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                winner = cand_idx[k];
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler driving the selects of a shared 4:1 mux, with settle delay before out_valid.
// Optional grant-hold timeout is built in when MUX_SCHED_TIMEOUT_EN is defined.
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int HOLD_MAX   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic               s0,
    output logic               s1,
    output logic [NUM_REQ-1:0] gnt,
    output logic               out_valid,
    output logic               busy
);

    if (SETTLE_CYC < 0 || SETTLE_CYC > 15 || HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_param_err
        $error("mux_rr_scheduler: SETTLE_CYC must be 0..15 and HOLD_MAX 1..255");
    end

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [SEL_W-1:0]     last_q, last_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [SETTLE_W-1:0]  cnt_q, cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;

    logic [NUM_REQ-1:0]   req_cand;
    logic [SEL_W-1:0]     pick_winner;
    logic                 pick_any;
    logic                 owner_req;
    logic                 preempt;
    logic                 issue;

    // The current owner is masked out so a handover or preemption never re-picks it.
    assign req_cand  = req & ~gnt_q;
    assign owner_req = |(req & gnt_q);

    rr_pick u_pick (
        .req    (req_cand),
        .last   (last_q),
        .winner (pick_winner),
        .any    (pick_any)
    );

`ifdef MUX_SCHED_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] hold_inc;

    assign hold_inc = (hold_q == HOLD_W'(HOLD_MAX)) ? hold_q : hold_q + HOLD_W'(1);
    // hold_inc reaching HOLD_MAX means this is the HOLD_MAX-th valid cycle of the grant.
    assign preempt  = (state_q == GRANT) && (hold_inc == HOLD_W'(HOLD_MAX)) && pick_any;

    always_comb begin
        hold_d = '0;
        if (state_q == GRANT && state_d == GRANT && !issue) begin
            hold_d = hold_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign preempt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            last_q      <= SEL_W'(NUM_REQ - 1);
            gnt_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    issue = 1'b1;
                end
            end
            SETTLE: begin
                if (!owner_req) begin
                    state_d = IDLE;
                end else if (cnt_q <= SETTLE_W'(1)) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!owner_req || preempt) begin
                    if (pick_any) begin
                        issue = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (issue) begin
            state_d = (SETTLE_CYC == 0) ? GRANT : SETTLE;
        end
    end

    // Selects only move on a fresh grant; leaving to IDLE clears gnt but keeps sel.
    always_comb begin
        sel_d  = sel_q;
        gnt_d  = gnt_q;
        last_d = last_q;
        cnt_d  = cnt_q;
        if (issue) begin
            sel_d  = pick_winner;
            gnt_d  = onehot(pick_winner);
            last_d = pick_winner;
            cnt_d  = SETTLE_W'(SETTLE_CYC);
        end else if (state_d == IDLE) begin
            gnt_d = '0;
        end else if (state_q == SETTLE) begin
            cnt_d = cnt_q - SETTLE_W'(1);
        end
        out_valid_d = (state_d == GRANT);
        busy_d      = (state_d != IDLE);
    end

    assign s0        = sel_q[0];
    assign s1        = sel_q[1];
    assign gnt       = gnt_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule
